rename_wide: RTL and testbench

RENAME_WIDE -- requirements
Module: rename_wide

---
 rtl/rename_wide_pkg.sv | 53 +++++
 rtl/rename_freelist.sv | 53 +++++
 rtl/rename_wide.sv | 181 ++++++++++++++++++
 tb/tb_rename_wide.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rename_wide_pkg.sv
// Shared rename types: register/ROB sizing, renamed lane record, branch checkpoint
// record and free-list pointer arithmetic.
package ooo_types;
   localparam int NUM_ARCH_REGS = 32;
   localparam int PHYS_REG_BITS = 7;
   localparam int ROB_BITS      = 4;
   localparam int NUM_PHYS_REGS = 1 << PHYS_REG_BITS;
   localparam int FL_DEPTH      = NUM_PHYS_REGS - NUM_ARCH_REGS;
   localparam int FL_IDX_BITS   = 7;
   localparam int CKPT_BITS     = 2;
   localparam int PAYLOAD_BITS  = 64;
   localparam logic [FL_IDX_BITS:0] FL_DEPTH_W = FL_DEPTH[FL_IDX_BITS:0];

   typedef logic [PHYS_REG_BITS-1:0] preg_t;

   // Wrap bit toggles each pass so full and empty are distinguishable.
   typedef struct packed {
      logic                   wrap;
      logic [FL_IDX_BITS-1:0] idx;
   } fl_ptr_t;

   typedef struct packed {
      preg_t                   prs1;
      preg_t                   prs2;
      preg_t                   prd;
      preg_t                   prd_old;
      logic [ROB_BITS-1:0]     rob_tag;
      logic [CKPT_BITS-1:0]    ckpt_id;
      logic                    is_branch;
      logic                    reg_write;
      logic [PAYLOAD_BITS-1:0] payload;
   } renamed_lane_t;

   typedef struct packed {
      preg_t [NUM_ARCH_REGS-1:0] map;
      fl_ptr_t                   head;
      logic [ROB_BITS-1:0]       rob_tag;
   } checkpoint_t;

   function automatic fl_ptr_t fl_ptr_add(input fl_ptr_t p, input logic [FL_IDX_BITS-1:0] n);
      logic [FL_IDX_BITS:0] sum;
      fl_ptr_t              r;
      sum = {1'b0, p.idx} + {1'b0, n};
      if (sum >= FL_DEPTH_W) begin
         r.idx  = FL_IDX_BITS'(sum - FL_DEPTH_W);
         r.wrap = ~p.wrap;
      end else begin
         r.idx  = sum[FL_IDX_BITS-1:0];
         r.wrap = p.wrap;
      end
      return r;
   endfunction
endpackage

// File: rtl/rename_freelist.sv
// Free physical-register FIFO: WIDTH-entry pop window at the head, in-order
// compacting push at the tail, head snapshot/restore for branch recovery.
module rename_freelist
   import ooo_types::*;
#(
   parameter int WIDTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [FL_IDX_BITS-1:0] i_pop_n,
   input  logic [WIDTH-1:0]       i_push_en,
   input  preg_t [WIDTH-1:0]      i_push_prd,
   input  logic                   i_restore,
   input  fl_ptr_t                i_restore_head,
   output preg_t [WIDTH-1:0]      o_pop_prd,
   output fl_ptr_t                o_head,
   output logic [FL_IDX_BITS:0]   o_count
);
   preg_t   r_mem [FL_DEPTH];
   fl_ptr_t r_head;
   fl_ptr_t r_tail;
   fl_ptr_t w_tail_nxt;
   fl_ptr_t w_push_slot [WIDTH];
   fl_ptr_t w_rd_ptr [WIDTH];

   always_comb begin
      w_tail_nxt = r_tail;
      for (int k = 0; k < WIDTH; k++) begin
         w_rd_ptr[k]    = fl_ptr_add(r_head, FL_IDX_BITS'(k));
         o_pop_prd[k]   = r_mem[w_rd_ptr[k].idx];
         w_push_slot[k] = w_tail_nxt;
         if (i_push_en[k]) w_tail_nxt = fl_ptr_add(w_tail_nxt, FL_IDX_BITS'(1));
      end
   end

   assign o_head  = r_head;
   assign o_count = (r_head.wrap == r_tail.wrap) ?
                    ({1'b0, r_tail.idx} - {1'b0, r_head.idx}) :
                    (FL_DEPTH_W - {1'b0, r_head.idx} + {1'b0, r_tail.idx});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head <= '0;
         r_tail <= '{wrap: 1'b1, idx: '0};
         for (int e = 0; e < FL_DEPTH; e++) r_mem[e] <= preg_t'(NUM_ARCH_REGS + e);
      end else begin
         r_head <= i_restore ? i_restore_head : fl_ptr_add(r_head, i_pop_n);
         r_tail <= w_tail_nxt;
         for (int k = 0; k < WIDTH; k++)
            if (i_push_en[k]) r_mem[w_push_slot[k].idx] <= i_push_prd[k];
      end
   end
endmodule

// File: rtl/rename_wide.sv
// WIDTH-lane register rename stage with intra-group forwarding, branch
// checkpoints (nested squash via older-masks) and a registered output group.
module rename_wide
   import ooo_types::*;
#(
   parameter int WIDTH     = 2,
   parameter int NUM_CKPT  = 4,
   parameter int PAYLOAD_W = 64
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [WIDTH-1:0]                valid_in,
   output logic                            ready_out,
   input  logic [WIDTH-1:0][4:0]           rs1_arch,
   input  logic [WIDTH-1:0][4:0]           rs2_arch,
   input  logic [WIDTH-1:0][4:0]           rd_arch,
   input  logic [WIDTH-1:0]                reg_write,
   input  logic [WIDTH-1:0]                is_branch,
   input  logic [WIDTH-1:0][PAYLOAD_W-1:0] payload_in,
   output logic [WIDTH-1:0]                valid_out,
   output renamed_lane_t [WIDTH-1:0]       renamed,
   input  logic                            ready_in,
   input  logic                            mispredict,
   input  logic [$clog2(NUM_CKPT)-1:0]     mispredict_ckpt,
   input  logic                            resolve_en,
   input  logic [$clog2(NUM_CKPT)-1:0]     resolve_ckpt,
   input  logic [WIDTH-1:0]                commit_en,
   input  logic [WIDTH-1:0][6:0]           commit_prd_old
);
   localparam int CW = $clog2(NUM_CKPT);

   preg_t [NUM_ARCH_REGS-1:0] r_map;
   logic [ROB_BITS-1:0]       r_rob_tag;
   logic [NUM_CKPT-1:0]       r_ckpt_vld;
   logic [NUM_CKPT-1:0]       r_older [NUM_CKPT];
   checkpoint_t               r_ckpt [NUM_CKPT];
   logic [WIDTH-1:0]          r_valid_out;
   renamed_lane_t [WIDTH-1:0] r_renamed;

   preg_t [NUM_ARCH_REGS-1:0] w_map;
   preg_t [WIDTH-1:0]         w_pop_prd, w_avail;
   renamed_lane_t [WIDTH-1:0] w_lane;
   checkpoint_t               w_cap;
   logic                      w_cap_en, w_ready, w_accept;
   logic [FL_IDX_BITS-1:0]    w_nalloc, w_pop_n;
   logic [ROB_BITS-1:0]       w_nvalid;
   logic [CW:0]               w_nbranch, w_nfree_ck;
   logic [CW-1:0]             w_free_slot;
   fl_ptr_t                   w_head;
   logic [FL_IDX_BITS:0]      w_fl_count;
   logic [WIDTH-1:0]          w_push_en;
   logic [NUM_CKPT-1:0]       w_vld_nxt;
   logic [NUM_CKPT-1:0]       w_older_nxt [NUM_CKPT];

   always_comb begin
      w_free_slot = '0;
      w_nfree_ck  = '0;
      for (int c = NUM_CKPT - 1; c >= 0; c--) begin
         if (!r_ckpt_vld[c]) begin
            w_free_slot = CW'(c);
            w_nfree_ck  = w_nfree_ck + 1'b1;
         end
      end
   end

   // Lanes are walked oldest first so each sees the map as left by earlier lanes.
   always_comb begin
      w_map     = r_map;
      w_avail   = w_pop_prd;
      w_nalloc  = '0;
      w_nvalid  = '0;
      w_nbranch = '0;
      w_cap     = '0;
      w_cap_en  = 1'b0;
      w_lane    = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_lane[i].prs1      = (rs1_arch[i] == '0) ? '0 : w_map[rs1_arch[i]];
         w_lane[i].prs2      = (rs2_arch[i] == '0) ? '0 : w_map[rs2_arch[i]];
         w_lane[i].rob_tag   = r_rob_tag + ROB_BITS'(i);
         w_lane[i].is_branch = is_branch[i];
         w_lane[i].reg_write = reg_write[i];
         w_lane[i].payload   = PAYLOAD_BITS'(payload_in[i]);
         if (valid_in[i]) w_nvalid = w_nvalid + 1'b1;
         if (valid_in[i] && reg_write[i] && (rd_arch[i] != '0)) begin
            w_lane[i].prd     = w_avail[0];
            w_lane[i].prd_old = w_map[rd_arch[i]];
            w_map[rd_arch[i]] = w_avail[0];
            w_avail           = w_avail >> PHYS_REG_BITS;
            w_nalloc          = w_nalloc + 1'b1;
         end
         if (valid_in[i] && is_branch[i]) begin
            w_nbranch         = w_nbranch + 1'b1;
            w_cap_en          = 1'b1;
            w_cap.map         = w_map;
            w_cap.head        = fl_ptr_add(w_head, w_nalloc);
            w_cap.rob_tag     = r_rob_tag + ROB_BITS'(i + 1);
            w_lane[i].ckpt_id = CKPT_BITS'(w_free_slot);
         end
      end
   end

   assign w_ready   = (!(|r_valid_out) || ready_in) && (w_fl_count >= {1'b0, w_nalloc})
                      && (w_nfree_ck >= w_nbranch) && !mispredict;
   assign w_accept  = (|valid_in) && w_ready;
   assign w_pop_n   = w_accept ? w_nalloc : '0;
   assign ready_out = w_ready;
   assign valid_out = r_valid_out;
   assign renamed   = r_renamed;

   always_comb begin
      for (int k = 0; k < WIDTH; k++)
         w_push_en[k] = commit_en[k] && (commit_prd_old[k] != '0);
   end

   // A mispredict on the slot being resolved must still squash its younger slots.
   always_comb begin
      w_vld_nxt   = r_ckpt_vld;
      w_older_nxt = r_older;
      if (resolve_en && !(mispredict && (resolve_ckpt == mispredict_ckpt))) begin
         w_vld_nxt[resolve_ckpt] = 1'b0;
         for (int c = 0; c < NUM_CKPT; c++) w_older_nxt[c][resolve_ckpt] = 1'b0;
      end
      if (mispredict) begin
         w_vld_nxt[mispredict_ckpt] = 1'b0;
         for (int c = 0; c < NUM_CKPT; c++)
            if (r_older[c][mispredict_ckpt]) w_vld_nxt[c] = 1'b0;
      end
      if (w_accept && w_cap_en) begin
         w_older_nxt[w_free_slot] = w_vld_nxt;
         w_vld_nxt[w_free_slot]   = 1'b1;
      end
   end

   rename_freelist #(.WIDTH(WIDTH)) u_freelist (
      .clk            (clk),
      .rst            (rst),
      .i_pop_n        (w_pop_n),
      .i_push_en      (w_push_en),
      .i_push_prd     (commit_prd_old),
      .i_restore      (mispredict),
      .i_restore_head (r_ckpt[mispredict_ckpt].head),
      .o_pop_prd      (w_pop_prd),
      .o_head         (w_head),
      .o_count        (w_fl_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int a = 0; a < NUM_ARCH_REGS; a++) r_map[a] <= preg_t'(a);
         for (int c = 0; c < NUM_CKPT; c++) r_older[c] <= '0;
         r_rob_tag   <= '0;
         r_ckpt_vld  <= '0;
         r_valid_out <= '0;
         r_renamed   <= '0;
      end else begin
         r_ckpt_vld <= w_vld_nxt;
         r_older    <= w_older_nxt;
         if (mispredict) begin
            r_map       <= r_ckpt[mispredict_ckpt].map;
            r_rob_tag   <= r_ckpt[mispredict_ckpt].rob_tag;
            r_valid_out <= '0;
         end else begin
            if (w_accept) begin
               r_map     <= w_map;
               r_rob_tag <= r_rob_tag + w_nvalid;
            end
            if (!(|r_valid_out) || ready_in) begin
               r_valid_out <= w_accept ? valid_in : '0;
               if (w_accept) r_renamed <= w_lane;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && w_accept && w_cap_en) r_ckpt[w_free_slot] <= w_cap;
   end

   a_one_branch: assert property (@(posedge clk) disable iff (rst)
      $countones(valid_in & is_branch) <= 1);
endmodule

// File: tb/tb_rename_wide.sv
// Directed bench for rename_wide: forwarding, x0 handling, checkpoints,
// mispredict recovery, free-list exhaustion/commit and output stall.
module tb_rename_wide;
   import ooo_types::*;

   logic                clk = 1'b0;
   logic                rst;
   logic [1:0]          valid_in;
   logic                ready_out;
   logic [1:0][4:0]     rs1_arch, rs2_arch, rd_arch;
   logic [1:0]          reg_write, is_branch;
   logic [1:0][63:0]    payload_in;
   logic [1:0]          valid_out;
   renamed_lane_t [1:0] renamed;
   logic                ready_in, mispredict, resolve_en;
   logic [1:0]          mispredict_ckpt, resolve_ckpt;
   logic [1:0]          commit_en;
   logic [1:0][6:0]     commit_prd_old;

   int n_checks = 0;
   int n_errors = 0;

   rename_wide #(.WIDTH(2), .NUM_CKPT(4), .PAYLOAD_W(64)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
      .rs1_arch(rs1_arch), .rs2_arch(rs2_arch), .rd_arch(rd_arch),
      .reg_write(reg_write), .is_branch(is_branch), .payload_in(payload_in),
      .valid_out(valid_out), .renamed(renamed), .ready_in(ready_in),
      .mispredict(mispredict), .mispredict_ckpt(mispredict_ckpt),
      .resolve_en(resolve_en), .resolve_ckpt(resolve_ckpt),
      .commit_en(commit_en), .commit_prd_old(commit_prd_old)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clr_in();
      valid_in = '0; rs1_arch = '0; rs2_arch = '0; rd_arch = '0;
      reg_write = '0; is_branch = '0; payload_in = '0;
   endtask

   task automatic set_lane(input int l, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic wr, input logic br);
      valid_in[l] = 1'b1; rs1_arch[l] = rs1; rs2_arch[l] = rs2; rd_arch[l] = rd;
      reg_write[l] = wr; is_branch[l] = br; payload_in[l] = 64'h1000 + 64'(l);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr_in();
      rst = 1'b1; ready_in = 1'b1; mispredict = 1'b0; resolve_en = 1'b0;
      mispredict_ckpt = '0; resolve_ckpt = '0; commit_en = '0; commit_prd_old = '0;
      step();
      rst = 1'b0;
   endtask

   task automatic chk_lane(input string t, input int l, input int p1, input int p2,
                           input int prd, input int old, input int tg);
      check({t, ".prs1"},    64'(renamed[l].prs1),    64'(p1));
      check({t, ".prs2"},    64'(renamed[l].prs2),    64'(p2));
      check({t, ".prd"},     64'(renamed[l].prd),     64'(prd));
      check({t, ".prd_old"}, 64'(renamed[l].prd_old), 64'(old));
      check({t, ".tag"},     64'(renamed[l].rob_tag), 64'(tg));
   endtask

   initial begin
      do_reset();
      check("rst.valid_out", 64'(valid_out), 64'd0);
      check("rst.renamed", 64'(renamed[0].prd) | 64'(renamed[1].rob_tag), 64'd0);
      check("rst.ready", 64'(ready_out), 64'd1);

      // add x1,x2,x3 ; add x4,x1,x2
      set_lane(0, 2, 3, 1, 1, 0); set_lane(1, 1, 2, 4, 1, 0);
      payload_in[1] = 64'hDEAD_BEEF_0000_1234;
      step();
      check("g1.valid", 64'(valid_out), 64'd3);
      chk_lane("g1.l0", 0, 2, 3, 32, 1, 0);
      chk_lane("g1.l1", 1, 32, 2, 33, 4, 1);
      check("g1.payload", renamed[1].payload, 64'hDEAD_BEEF_0000_1234);

      // downstream stall with the next group waiting
      ready_in = 1'b0; clr_in();
      set_lane(0, 1, 0, 5, 1, 0); set_lane(1, 5, 5, 5, 1, 0);
      #1 check("stall.ready", 64'(ready_out), 64'd0);
      for (int c = 0; c < 3; c++) begin
         step();
         check("stall.valid", 64'(valid_out), 64'd3);
         check("stall.prd0", 64'(renamed[0].prd), 64'd32);
         check("stall.prd1", 64'(renamed[1].prd), 64'd33);
      end
      ready_in = 1'b1;
      #1 check("unstall.ready", 64'(ready_out), 64'd1);
      step();
      chk_lane("g2.l0", 0, 32, 0, 34, 5, 2);
      chk_lane("g2.l1", 1, 34, 34, 35, 34, 3);

      // store ; add x0
      clr_in(); set_lane(0, 5, 4, 0, 0, 0); set_lane(1, 5, 0, 0, 1, 0);
      step();
      chk_lane("g3.l0", 0, 35, 33, 0, 0, 4);
      chk_lane("g3.l1", 1, 35, 0, 0, 0, 5);

      // branch(ckpt0) ; x6,x7 ; branch(ckpt1) ; mispredict ckpt0
      clr_in(); set_lane(0, 1, 4, 0, 0, 1);
      step();
      check("bra.valid", 64'(valid_out), 64'd1);
      check("bra.ckpt", 64'(renamed[0].ckpt_id), 64'd0);
      chk_lane("bra.l0", 0, 32, 33, 0, 0, 6);
      clr_in(); set_lane(0, 2, 0, 6, 1, 0); set_lane(1, 6, 0, 7, 1, 0);
      step();
      chk_lane("g67.l0", 0, 2, 0, 36, 6, 7);
      chk_lane("g67.l1", 1, 36, 0, 37, 7, 8);
      clr_in(); set_lane(0, 7, 0, 0, 0, 1);
      step();
      check("brb.ckpt", 64'(renamed[0].ckpt_id), 64'd1);
      chk_lane("brb.l0", 0, 37, 0, 0, 0, 9);
      clr_in(); mispredict = 1'b1; mispredict_ckpt = 2'd0;
      #1 check("mp.ready", 64'(ready_out), 64'd0);
      step();
      mispredict = 1'b0;
      check("mp.valid", 64'(valid_out), 64'd0);
      set_lane(0, 0, 0, 8, 1, 0); set_lane(1, 6, 7, 0, 0, 1);
      step();
      chk_lane("rec.l0", 0, 0, 0, 36, 8, 7);
      chk_lane("rec.l1", 1, 6, 7, 0, 0, 8);
      check("rec.ckpt", 64'(renamed[1].ckpt_id), 64'd0);
      clr_in(); set_lane(0, 8, 0, 0, 0, 1);
      step();
      check("rec2.ckpt", 64'(renamed[0].ckpt_id), 64'd1);
      check("rec2.prs1", 64'(renamed[0].prs1), 64'd36);

      // checkpoint exhaustion and resolve
      do_reset();
      for (int g = 0; g < 4; g++) begin
         clr_in(); set_lane(0, 0, 0, 0, 0, 1);
         step();
         check("fill.ckpt", 64'(renamed[0].ckpt_id), 64'(g));
      end
      clr_in(); set_lane(0, 0, 0, 0, 0, 1);
      #1 check("full.ready", 64'(ready_out), 64'd0);
      step();
      check("full.valid", 64'(valid_out), 64'd0);
      resolve_en = 1'b1; resolve_ckpt = 2'd1;
      #1 check("res.ready_same", 64'(ready_out), 64'd0);
      step();
      resolve_en = 1'b0;
      #1 check("res.ready_next", 64'(ready_out), 64'd1);
      step();
      check("res.valid", 64'(valid_out), 64'd1);
      check("res.ckpt", 64'(renamed[0].ckpt_id), 64'd1);
      check("res.tag", 64'(renamed[0].rob_tag), 64'd4);

      // resolve and mispredict on the same slot: younger slots still squashed
      clr_in(); mispredict = 1'b1; mispredict_ckpt = 2'd2;
      resolve_en = 1'b1; resolve_ckpt = 2'd2;
      step();
      mispredict = 1'b0; resolve_en = 1'b0;
      check("mpres.valid", 64'(valid_out), 64'd0);
      set_lane(0, 0, 0, 0, 0, 1);
      step();
      check("mpres.ckpt", 64'(renamed[0].ckpt_id), 64'd1);
      check("mpres.tag", 64'(renamed[0].rob_tag), 64'd3);

      // free-list exhaustion and commit
      do_reset();
      for (int g = 0; g < 48; g++) begin
         clr_in();
         set_lane(0, 0, 0, 5'(g % 31 + 1), 1, 0);
         set_lane(1, 0, 0, 5'((g + 7) % 31 + 1), 1, 0);
         step();
         if (g == 0) check("fl.first", 64'(renamed[0].prd), 64'd32);
      end
      check("fl.last0", 64'(renamed[0].prd), 64'd126);
      check("fl.last1", 64'(renamed[1].prd), 64'd127);
      clr_in(); set_lane(0, 0, 0, 3, 1, 0);
      #1 check("fl.empty_ready", 64'(ready_out), 64'd0);
      step();
      check("fl.empty_valid", 64'(valid_out), 64'd0);
      commit_en = 2'b11; commit_prd_old[0] = 7'd1; commit_prd_old[1] = 7'd0;
      #1 check("fl.commit_same", 64'(ready_out), 64'd0);
      step();
      commit_en = '0;
      #1 check("fl.commit_next", 64'(ready_out), 64'd1);
      step();
      check("fl.reuse_valid", 64'(valid_out), 64'd1);
      check("fl.reuse_prd", 64'(renamed[0].prd), 64'd1);
      #1 check("fl.p0_ignored", 64'(ready_out), 64'd0);
      clr_in(); set_lane(0, 1, 2, 0, 0, 0);
      #1 check("fl.store_ready", 64'(ready_out), 64'd1);
      step();
      clr_in();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
